// File: rtl/alu_result_reader.sv
// alu_result_reader: scans the ALU result memory through its synchronous read port
// and streams {addr, y, c} beats over valid/ready while counting entries with c set.
module alu_result_reader #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 4,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_y,
    input  logic              mem_c,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_y,
    output logic              out_c,
    output logic [ADDR_W:0]   flag_cnt
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_CAP  = 3'd2,
        S_OUT  = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   addr_d;
    logic [ADDR_W:0]     flag_cnt_q;
    logic [ADDR_W:0]     flag_cnt_d;
    logic                busy_q;
    logic                done_q;
    logic                mem_re_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic                out_valid_q;
    logic [ADDR_W-1:0]   out_addr_q;
    logic [DATA_W-1:0]   out_y_q;
    logic                out_c_q;

    // Next scan address and the flag count including the entry being captured.
    always_comb begin
        addr_d     = addr_q + ADDR_W'(1);
        flag_cnt_d = flag_cnt_q;
        if (mem_c) begin
            flag_cnt_d = flag_cnt_q + (ADDR_W + 1)'(1);
        end else begin
            flag_cnt_d = flag_cnt_q;
        end
    end

    // Scan FSM; every output is a register updated on the transition into its state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            flag_cnt_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_addr_q  <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_y_q     <= '0;
            out_c_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q    <= S_RD;
                        addr_q     <= '0;
                        flag_cnt_q <= '0;
                        busy_q     <= 1'b1;
                        mem_re_q   <= 1'b1;
                        mem_addr_q <= '0;
                    end
                end
                S_RD: begin
                    state_q  <= S_CAP;
                    mem_re_q <= 1'b0;
                end
                S_CAP: begin
                    // Read data is valid now, one cycle after the strobe.
                    state_q     <= S_OUT;
                    out_y_q     <= mem_y;
                    out_c_q     <= mem_c;
                    out_addr_q  <= addr_q;
                    flag_cnt_q  <= flag_cnt_d;
                    out_valid_q <= 1'b1;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (addr_q == LAST_ADDR) begin
                            state_q <= S_FIN;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= S_RD;
                            addr_q     <= addr_d;
                            mem_re_q   <= 1'b1;
                            mem_addr_q <= addr_d;
                        end
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q     <= S_IDLE;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                    mem_re_q    <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign mem_re    = mem_re_q;
    assign mem_addr  = mem_addr_q;
    assign out_valid = out_valid_q;
    assign out_addr  = out_addr_q;
    assign out_y     = out_y_q;
    assign out_c     = out_c_q;
    assign flag_cnt  = flag_cnt_q;

endmodule
